// File: rtl/mips16_wb_pkg.sv
// Shared widths and the write-request record used by the register-file write
// arbiter, its result FIFO and its output registers.
package mips16_wb_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of pipeline writeback, long-latency result, scoreboard, decode and
// register-file write signals seen by the write arbiter.
interface reg_write_arbiter_if;
    import mips16_wb_pkg::*;

    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     wb_data;
    logic                  lu_valid;
    logic                  lu_ready;
    logic [REG_ADDR_W-1:0] lu_dest;
    logic [DATA_W-1:0]     lu_data;
    logic                  sb_set_en;
    logic [REG_ADDR_W-1:0] sb_set_dest;
    logic [REG_ADDR_W-1:0] rd_addr_1;
    logic [REG_ADDR_W-1:0] rd_addr_2;
    logic                  stall;
    logic                  reg_write_en;
    logic [REG_ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0]     reg_write_data;

    modport master (
        output wb_en, wb_dest, wb_data,
        output lu_valid, lu_dest, lu_data,
        output sb_set_en, sb_set_dest,
        output rd_addr_1, rd_addr_2,
        input  lu_ready, stall,
        input  reg_write_en, reg_write_dest, reg_write_data
    );

    modport slave (
        input  wb_en, wb_dest, wb_data,
        input  lu_valid, lu_dest, lu_data,
        input  sb_set_en, sb_set_dest,
        input  rd_addr_1, rd_addr_2,
        output lu_ready, stall,
        output reg_write_en, reg_write_dest, reg_write_data
    );

endinterface

// File: rtl/lu_fifo.sv
// Small FIFO buffering long-latency results until the write port is free.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module lu_fifo
    import mips16_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wr_req_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    wr_req_t        mem_q [DEPTH];
    wr_req_t        mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/reg_write_arbiter.sv
// Drives the register file's single write port from the pipeline writeback
// (absolute priority) and buffered long-latency results; tracks pending dests.
module reg_write_arbiter
    import mips16_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    reg_write_arbiter_if.slave bus
);

    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    wr_req_t fifo_head;
    wr_req_t lu_req;

    logic                wr_en_q, wr_en_d;
    wr_req_t             wr_q, wr_d;
    logic                from_lu_q, from_lu_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    assign lu_req    = {bus.lu_dest, bus.lu_data};
    assign fifo_push = bus.lu_valid && !fifo_full;
    assign fifo_pop  = !bus.wb_en && !fifo_empty;

    lu_fifo #(.DEPTH(DEPTH)) u_lu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (lu_req),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // r0 writes are dropped here, but a dest-0 FIFO entry is still consumed.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_d      = wr_q;
        from_lu_d = 1'b0;
        if (bus.wb_en) begin
            wr_en_d = (bus.wb_dest != '0);
            wr_d    = {bus.wb_dest, bus.wb_data};
        end else if (!fifo_empty) begin
            wr_en_d   = (fifo_head.dest != '0);
            wr_d      = fifo_head;
            from_lu_d = 1'b1;
        end
    end

    // Clear applied before set so a same-cycle set on the same dest wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q && from_lu_q) begin
            pending_d[wr_q.dest] = 1'b0;
        end
        if (bus.sb_set_en) begin
            pending_d[bus.sb_set_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_q      <= '0;
            from_lu_q <= 1'b0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_q      <= wr_d;
            from_lu_q <= from_lu_d;
            pending_q <= pending_d;
        end
    end

    assign bus.lu_ready       = !fifo_full;
    assign bus.stall          = pending_q[bus.rd_addr_1] | pending_q[bus.rd_addr_2];
    assign bus.reg_write_en   = wr_en_q;
    assign bus.reg_write_dest = wr_q.dest;
    assign bus.reg_write_data = wr_q.data;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: expected writes are queued as stimulus
// is issued, and a monitor pops and compares every register-file write.
module tb_reg_write_arbiter;
    import mips16_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_write_arbiter_if bus ();

    reg_write_arbiter #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int      n_cmp = 0;
    int      n_bad = 0;
    wr_req_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_wr(input logic [2:0] dest, input logic [15:0] data);
        wr_req_t e;
        e.dest = dest;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.wb_en       = 1'b0;
        bus.wb_dest     = '0;
        bus.wb_data     = '0;
        bus.lu_valid    = 1'b0;
        bus.lu_dest     = '0;
        bus.lu_data     = '0;
        bus.sb_set_en   = 1'b0;
        bus.sb_set_dest = '0;
        bus.rd_addr_1   = '0;
        bus.rd_addr_2   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] dest, input logic [15:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_dest = dest;
        bus.wb_data = data;
    endtask

    task automatic lu(input logic [2:0] dest, input logic [15:0] data);
        bus.lu_valid = 1'b1;
        bus.lu_dest  = dest;
        bus.lu_data  = data;
    endtask

    // Write monitor: every observed write must match the head of the queue.
    initial begin
        wr_req_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.reg_write_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got dest %0d data %h, expected no write (t=%0t)",
                             bus.reg_write_dest, bus.reg_write_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_dest", 32'(bus.reg_write_dest), 32'(e.dest));
                    chk("write_data", 32'(bus.reg_write_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            bus.rd_addr_1 = 3'(i);
            bus.rd_addr_2 = 3'(i + 3);
            @(negedge clk);
            chk("idle_en", 32'(bus.reg_write_en), 0);
            chk("idle_ready", 32'(bus.lu_ready), 1);
            chk("idle_stall", 32'(bus.stall), 0);
            step();
        end
        idle_inputs();

        // Pipeline writeback, 1-cycle latency, single-cycle pulse
        wb(3, 16'h1234);
        expect_wr(3, 16'h1234);
        @(negedge clk);
        chk("wb_en_n", 32'(bus.reg_write_en), 0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("wb_en_n1", 32'(bus.reg_write_en), 1);
        step();
        @(negedge clk);
        chk("wb_en_n2", 32'(bus.reg_write_en), 0);
        step();

        // Long-latency r5 with stall window
        bus.sb_set_en   = 1'b1;
        bus.sb_set_dest = 3'd5;
        bus.rd_addr_1   = 3'd5;
        @(negedge clk);
        chk("lu5_stall_pre", 32'(bus.stall), 0);
        step();
        bus.sb_set_en = 1'b0;
        lu(5, 16'hBEEF);
        expect_wr(5, 16'hBEEF);
        @(negedge clk);
        chk("lu5_stall_n", 32'(bus.stall), 1);
        chk("lu5_ready_n", 32'(bus.lu_ready), 1);
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        chk("lu5_stall_n1", 32'(bus.stall), 1);
        chk("lu5_en_n1", 32'(bus.reg_write_en), 0);
        step();
        @(negedge clk);
        chk("lu5_stall_n2", 32'(bus.stall), 1);
        chk("lu5_en_n2", 32'(bus.reg_write_en), 1);
        step();
        @(negedge clk);
        chk("lu5_stall_n3", 32'(bus.stall), 0);
        chk("lu5_en_n3", 32'(bus.reg_write_en), 0);
        step();
        idle_inputs();

        // wb held 4 cycles while the FIFO fills; full push+pop cycle; in-order drain
        expect_wr(1, 16'h1111);
        expect_wr(2, 16'h2222);
        expect_wr(3, 16'h3333);
        expect_wr(5, 16'h5555);
        expect_wr(6, 16'h6666);
        expect_wr(7, 16'h7777);
        expect_wr(4, 16'h4444);
        wb(1, 16'h1111);
        lu(6, 16'h6666);
        @(negedge clk);
        chk("fill_ready_c0", 32'(bus.lu_ready), 1);
        step();
        wb(2, 16'h2222);
        lu(7, 16'h7777);
        @(negedge clk);
        chk("fill_ready_c1", 32'(bus.lu_ready), 1);
        step();
        wb(3, 16'h3333);
        bus.lu_valid = 1'b0;
        @(negedge clk);
        chk("fill_ready_c2", 32'(bus.lu_ready), 0);
        step();
        wb(5, 16'h5555);
        @(negedge clk);
        chk("fill_ready_c3", 32'(bus.lu_ready), 0);
        step();
        bus.wb_en = 1'b0;
        lu(4, 16'h4444);
        @(negedge clk);
        chk("fill_ready_c4", 32'(bus.lu_ready), 0);
        step();
        @(negedge clk);
        chk("fill_ready_c5", 32'(bus.lu_ready), 1);
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        chk("fill_ready_c6", 32'(bus.lu_ready), 1);
        step();
        repeat (3) step();
        idle_inputs();

        // Long-latency write to r0 is consumed but never written
        lu(0, 16'hABCD);
        @(negedge clk);
        chk("r0_stall_n", 32'(bus.stall), 0);
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        chk("r0_stall_n1", 32'(bus.stall), 0);
        step();
        @(negedge clk);
        chk("r0_en_n2", 32'(bus.reg_write_en), 0);
        chk("r0_stall_n2", 32'(bus.stall), 0);
        step();
        @(negedge clk);
        chk("r0_ready", 32'(bus.lu_ready), 1);
        step();

        // Set and clear of r2 in the same cycle: set wins
        bus.sb_set_en   = 1'b1;
        bus.sb_set_dest = 3'd2;
        bus.rd_addr_2   = 3'd2;
        step();
        bus.sb_set_en = 1'b0;
        lu(2, 16'h2A2A);
        expect_wr(2, 16'h2A2A);
        @(negedge clk);
        chk("r2_stall_m1", 32'(bus.stall), 1);
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        chk("r2_stall_m2", 32'(bus.stall), 1);
        step();
        bus.sb_set_en = 1'b1;
        @(negedge clk);
        chk("r2_en_m3", 32'(bus.reg_write_en), 1);
        step();
        bus.sb_set_en = 1'b0;
        @(negedge clk);
        chk("r2_stall_setwins", 32'(bus.stall), 1);
        step();
        @(negedge clk);
        chk("r2_stall_held", 32'(bus.stall), 1);
        lu(2, 16'h3B3B);
        expect_wr(2, 16'h3B3B);
        step();
        bus.lu_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("r2_stall_cleared", 32'(bus.stall), 0);
        step();
        idle_inputs();

        // Reset mid-burst discards buffered result and pending bit
        bus.sb_set_en   = 1'b1;
        bus.sb_set_dest = 3'd4;
        wb(1, 16'hA1A1);
        expect_wr(1, 16'hA1A1);
        step();
        bus.sb_set_en = 1'b0;
        wb(2, 16'hB2B2);
        lu(4, 16'hC3C3);
        step();
        chk("prerst_en", 32'(bus.reg_write_en), 1);
        idle_inputs();
        bus.rd_addr_1 = 3'd4;
        #2 rst = 1'b1;
        #1;
        chk("rst_en", 32'(bus.reg_write_en), 0);
        chk("rst_dest", 32'(bus.reg_write_dest), 0);
        chk("rst_data", 32'(bus.reg_write_data), 0);
        chk("rst_ready", 32'(bus.lu_ready), 1);
        chk("rst_stall", 32'(bus.stall), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_en", 32'(bus.reg_write_en), 0);
            chk("postrst_stall", 32'(bus.stall), 0);
            step();
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        chk("drain_remaining", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Sits directly upstream of the 8-entry, 16-bit register file and drives its single synchronous write port. Merges two write sources: the in-order pipeline writeback (never stalled) and a long-latency unit (mul/div) with a valid/ready handshake buffered in a small FIFO. Keeps a pending-write scoreboard so decode can stall reads of registers whose long-latency result has not yet been written.

## Interface
- DEPTH, 2: long-latency result FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_en  in  1  pipeline writeback valid; has absolute priority and is never back-pressured.
- wb_dest  in  3  pipeline writeback destination.
- wb_data  in  16  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept; equals FIFO not full, independent of lu_valid.
- lu_dest  in  3  long-latency destination.
- lu_data  in  16  long-latency data.
- sb_set_en  in  1  long-latency op issued this cycle; marks sb_set_dest pending.
- sb_set_dest  in  3  destination of the issued op.
- rd_addr_1, rd_addr_2  in  3 each  decode read addresses.
- stall  out  1  combinational; high if rd_addr_1 or rd_addr_2 is pending (non-zero address).
- reg_write_en  out  1  registered write enable to the register file.
- reg_write_dest  out  3  registered write destination.
- reg_write_data  out  16  registered write data.

## Operation
- Accept: lu_valid && lu_ready pushes {lu_dest, lu_data} into the FIFO.
- Arbitration each cycle: if wb_en, load the output registers from wb_*; else if FIFO non-empty, pop the head into the output registers; else reg_write_en <= 0.
- The FIFO holds its contents while wb_en is high; no entry is lost or reordered.
- Writes to r0 from either source are dropped: reg_write_en stays 0, but a FIFO entry with dest 0 is still popped.
- Scoreboard: 8 pending bits; bit 0 is hard-wired 0.
  - Set when sb_set_en.
  - Cleared on the edge at which reg_write_en is high for a FIFO-sourced write to that dest. An internal from_lu flag marks the source of the output registers.
  - Set and clear of the same dest in the same cycle: set wins.
- WAW between pipeline and pending long-latency dest is not checked here; decode prevents it via stall.
- Push and pop in the same cycle are legal, including when the FIFO is full: lu_ready is still low that cycle, so no push occurs.
- Reset values: FIFO empty, all pointers 0, all pending bits 0, reg_write_en/dest/data = 0, from_lu = 0, lu_ready = 1, stall = 0.
- Reset mid-operation: buffered results and pending bits are discarded immediately.

## Timing
- Pipeline path latency is 1 cycle: wb_en in cycle N gives reg_write_en in N+1; the register file is updated at the end of N+1.
- Long-latency path, minimum 2 cycles:
  - Push at the end of N.
  - Pop at the end of N+1 if wb_en is low in N+1.
  - reg_write_en high in N+2; the pending bit clears at the end of N+2.
- stall is high through N+2; first stall-free read is N+3, which sees the new value.
- Each cycle wb_en is high delays the FIFO drain by exactly 1 cycle.
- lu_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop that frees an entry.

## Structure
- Package mips16_wb_pkg:
  - Constants: DATA_W=16, REG_ADDR_W=3, NUM_REGS=8.
  - Typedef wr_req_t {dest, data} used for FIFO entries and the output registers.
- Sub-module lu_fifo (parameter DEPTH):
  - Ports: push/pop, full/empty, head.
  - Pointers carry one extra wrap bit for full/empty detection.
- The top level holds the arbiter, output registers, from_lu flag, scoreboard and stall logic.

## Test plan
- Reset then idle → reg_write_en=0, lu_ready=1, stall=0 for 10 cycles; assert rst mid-burst → outputs return to 0 asynchronously.
- wb_en=1, wb_dest=3, wb_data=16'h1234 in cycle N → reg_write_en=1, dest=3, data=16'h1234 in N+1 only.
- sb_set r5, then lu push r5/16'hBEEF at N with rd_addr_1=5 → stall=1 through N+2, reg_write_en with 16'hBEEF in N+2, stall=0 in N+3.
- wb_en held high 4 cycles while 2 lu results are pushed → lu_ready=0 after the second push; FIFO drains in order in the 2 cycles after wb_en drops; no loss.
- lu push with dest 0 → no reg_write_en; FIFO empties; stall never asserted for rd_addr 0.
- sb_set_en for r2 in the same cycle r2's FIFO write clears → r2 remains pending; stall=1 for rd_addr_2=2.
